// File: rtl/midi_voice_allocator.sv
// MIDI byte-stream parser and 16-voice note allocator driving per-voice Q12.20 pitch.
// Pipeline: input byte register -> parser event register -> voice state registers.
module midi_voice_allocator #(
    parameter int unsigned MIDI_CHANNEL = 0,
    parameter bit          OMNI         = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] frequency [16],
    output logic [15:0] voice_active
);

    localparam int unsigned NUM_VOICES = 16;
    localparam int unsigned VIDX_W     = 4;
    localparam int unsigned NOTE_W     = 7;
    localparam int unsigned FREQ_W     = 32;

    localparam logic [NOTE_W-1:0] MAX_NOTE         = 7'd107;
    localparam logic [NOTE_W-1:0] CC_ALL_NOTES_OFF = 7'd123;

    // Status type is the upper nibble minus 8 (8x..Ex -> 0..6)
    localparam logic [2:0] T_NOTE_OFF   = 3'd0;
    localparam logic [2:0] T_NOTE_ON    = 3'd1;
    localparam logic [2:0] T_CC         = 3'd3;
    localparam logic [2:0] T_PROGRAM    = 3'd4;
    localparam logic [2:0] T_CHAN_PRESS = 3'd5;

    typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF, EV_ALL_OFF} event_t;

    logic              rx_valid_q;
    logic [7:0]        rx_data_q;

    state_t            state_q, state_d;
    logic              rs_valid_q, rs_valid_d;
    logic [2:0]        rs_type_q, rs_type_d;
    logic [3:0]        rs_chan_q, rs_chan_d;
    logic [NOTE_W-1:0] data1_q, data1_d;
    event_t            ev_q, ev_d;
    logic [NOTE_W-1:0] ev_note_q, ev_note_d;
    logic              take_data1;
    logic              chan_ok;

    logic [NOTE_W-1:0] note_q [NUM_VOICES];
    logic [NOTE_W-1:0] note_d [NUM_VOICES];
    logic [FREQ_W-1:0] freq_d [NUM_VOICES];
    logic [15:0]       active_d;
    logic [VIDX_W-1:0] steal_q, steal_d;
    logic              hit, free_found, wr_en;
    logic [VIDX_W-1:0] hit_idx, free_idx, wr_idx;
    logic [FREQ_W-1:0] pitch;

    // Octave-8 pitches (notes 96..107) in Q12.20, rounded to nearest
    function automatic logic [FREQ_W-1:0] base_rom(input logic [3:0] semi);
        case (semi)
            4'd0:    return 32'h82D0_1286;
            4'd1:    return 32'h8A97_6074;
            4'd2:    return 32'h92D5_171D;
            4'd3:    return 32'h9B90_4101;
            4'd4:    return 32'hA4D0_53C9;
            4'd5:    return 32'hAE9D_36B0;
            4'd6:    return 32'hB8FF_493E;
            4'd7:    return 32'hC3FF_6A72;
            4'd8:    return 32'hCFA7_0055;
            4'd9:    return 32'hDC00_0000;
            4'd10:   return 32'hE914_F623;
            4'd11:   return 32'hF6F1_1004;
            default: return '0;
        endcase
    endfunction

    function automatic logic [FREQ_W-1:0] note_pitch(input logic [NOTE_W-1:0] n);
        logic [NOTE_W-1:0] octave;
        logic [3:0]        semi;
        logic [3:0]        shift;
        octave = n / 7'd12;
        semi   = 4'(n % 7'd12);
        shift  = 4'(7'd8 - octave);
        return base_rom(semi) >> shift;
    endfunction

    assign chan_ok = OMNI || (rs_chan_q == 4'(MIDI_CHANNEL));

    // Parser registers: input byte, FSM, running status, captured data, event
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            state_q    <= IDLE;
            rs_valid_q <= 1'b0;
            rs_type_q  <= '0;
            rs_chan_q  <= '0;
            data1_q    <= '0;
            ev_q       <= EV_NONE;
            ev_note_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            rx_data_q  <= rx_data;
            state_q    <= state_d;
            rs_valid_q <= rs_valid_d;
            rs_type_q  <= rs_type_d;
            rs_chan_q  <= rs_chan_d;
            data1_q    <= data1_d;
            ev_q       <= ev_d;
            ev_note_q  <= ev_note_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rs_valid_d = rs_valid_q;
        rs_type_d  = rs_type_q;
        rs_chan_d  = rs_chan_q;
        data1_d    = data1_q;
        ev_d       = EV_NONE;
        ev_note_d  = ev_note_q;
        take_data1 = 1'b0;
        if (rx_valid_q) begin
            if (rx_data_q[7]) begin
                if (rx_data_q[7:4] != 4'hF) begin
                    rs_valid_d = 1'b1;
                    rs_type_d  = rx_data_q[6:4];
                    rs_chan_d  = rx_data_q[3:0];
                    state_d    = DATA1;
                end else if (!rx_data_q[3]) begin
                    // System common: drop running status; realtime (F8-FF) falls through untouched
                    rs_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end else begin
                case (state_q)
                    IDLE:  take_data1 = rs_valid_q;
                    DATA1: take_data1 = 1'b1;
                    DATA2: begin
                        state_d   = IDLE;
                        ev_note_d = data1_q;
                        if (chan_ok) begin
                            case (rs_type_q)
                                T_NOTE_OFF: ev_d = EV_OFF;
                                T_NOTE_ON:  ev_d = (rx_data_q[6:0] == '0) ? EV_OFF : EV_ON;
                                T_CC:       if (data1_q == CC_ALL_NOTES_OFF) ev_d = EV_ALL_OFF;
                                default:    ev_d = EV_NONE;
                            endcase
                        end
                    end
                    default: state_d = IDLE;
                endcase
                if (take_data1) begin
                    data1_d = rx_data_q[6:0];
                    state_d = (rs_type_q == T_PROGRAM || rs_type_q == T_CHAN_PRESS) ? IDLE : DATA2;
                end
            end
        end
    end

    // Allocator: find held/free voices, then apply at most one write
    always_comb begin
        active_d   = voice_active;
        note_d     = note_q;
        freq_d     = frequency;
        steal_d    = steal_q;
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        pitch      = note_pitch(ev_note_q);
        for (int j = int'(NUM_VOICES) - 1; j >= 0; j--) begin
            if (voice_active[j] && note_q[j] == ev_note_q) begin
                hit     = 1'b1;
                hit_idx = VIDX_W'(j);
            end
            if (!voice_active[j]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(j);
            end
        end
        case (ev_q)
            EV_ON: begin
                if (ev_note_q <= MAX_NOTE) begin
                    wr_en = 1'b1;
                    if (hit) begin
                        wr_idx = hit_idx;
                    end else if (free_found) begin
                        wr_idx = free_idx;
                    end else begin
                        wr_idx  = steal_q;
                        steal_d = steal_q + VIDX_W'(1);
                    end
                end
            end
            EV_OFF: begin
                if (hit) begin
                    active_d[hit_idx] = 1'b0;
                    freq_d[hit_idx]   = '0;
                end
            end
            EV_ALL_OFF: begin
                active_d = '0;
                for (int j = 0; j < int'(NUM_VOICES); j++) freq_d[j] = '0;
            end
            default: ;
        endcase
        if (wr_en) begin
            active_d[wr_idx] = 1'b1;
            note_d[wr_idx]   = ev_note_q;
            freq_d[wr_idx]   = pitch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            voice_active <= '0;
            steal_q      <= '0;
            for (int j = 0; j < int'(NUM_VOICES); j++) begin
                frequency[j] <= '0;
                note_q[j]    <= '0;
            end
        end else begin
            voice_active <= active_d;
            steal_q      <= steal_d;
            frequency    <= freq_d;
            note_q       <= note_d;
        end
    end

endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Front end of the polyphonic synthesizer. It parses a MIDI byte stream, such as bytes from the UART receiver. It allocates Note On/Off events to 16 voices and drives the per-voice 32-bit `frequency` array that the synthesizer's oscillators divide into wavelengths. It is the producer of that frequency interface; the synthesizer is the consumer.

## Interface
Parameters:
- `MIDI_CHANNEL`, default 0: channel (0-15) the block responds to.
- `OMNI`, default 0: when 1, the block responds to all channels.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `rx_valid`  in  1: `rx_data` holds a new byte this cycle. It may be asserted every cycle; there is no backpressure.
- `rx_data`  in  8: MIDI byte.
- `frequency[15:0]`  out  32 each: voice pitch in Hz, unsigned Q12.20. The value is 0 when the voice is free.
- `voice_active`  out  16: bit j is 1 while voice j holds a note.

## Operation
**Parser FSM.** States are IDLE, DATA1 and DATA2.
- Status byte 0x80-0xEF:
  - Latches the running status (type and channel).
  - Goes to DATA1.
- Status byte 0xF0-0xF7:
  - Clears running status.
  - Goes to IDLE; following data bytes are ignored until the next channel status byte.
- Realtime byte 0xF8-0xFF: ignored completely. State, running status and the captured data byte are unchanged.
- Data byte (bit7 = 0):
  - In IDLE with a valid running status, it is treated as the first data byte (DATA1 behaviour).
  - In DATA1, it captures the note (or controller number).
  - For 2-byte types (8x, 9x, Bx, Ax, Ex), the FSM goes to DATA2; for 1-byte types (Cx, Dx), the byte is consumed and the FSM returns to IDLE.
  - In DATA2, it captures the velocity (or value), emits one event, and returns to IDLE with running status kept.
- Events are emitted only when the channel matches (`OMNI` or channel == `MIDI_CHANNEL`). Only three event kinds are used:
  - Note On (9x, velocity > 0).
  - Note Off (8x, or 9x with velocity 0).
  - CC 123 "all notes off" (Bx, controller 123, any value).
  - All other messages are parsed and discarded.

**Allocator**, handling one event per cycle:
- Note On for note n > 107: ignored, because it exceeds the Q12.20 range.
- Note On when n is already held by voice j: voice j is retriggered. Frequency is rewritten to the same value and no second voice is used.
- Note On otherwise:
  - Takes the lowest-index free voice.
  - If all 16 voices are busy, it steals voice `steal_ptr`, and `steal_ptr` increments mod 16.
- Note Off n: the voice holding n is freed (`voice_active` = 0, `frequency` = 0). If n is not held, nothing happens.
- CC 123: all voices are freed. `steal_ptr` is unchanged.
- Per-voice state is `active`, `note[6:0]` and `frequency`.

**Pitch.**
- `frequency` = BASE[n mod 12] >> (8 − n/12), for n ≤ 107.
- BASE is a 12-entry ROM of octave-8 pitches (notes 96-107, C7-B7) in Q12.20, rounded to nearest. A7 (note 105) = 3520.0 = 0xDC000000.
- Reference values: note 69 = 0x1B800000 (440 Hz); note 81 = 0x37000000; note 57 = 0x0DC00000.

## Timing
- Reset values: all `frequency` = 0, `voice_active` = 0, FSM = IDLE, running status cleared, `steal_ptr` = 0.
- Latency: the final byte is accepted at edge N; the parser event is registered at edge N+1; outputs update at edge N+2. Both outputs change in the same cycle.
- Back-to-back bytes (1 per cycle) are supported with no drops. Events are at least 2 cycles apart, so the allocator never sees two events in one cycle.
- An event whose allocator write happens at edge N+2 sees all allocator updates up to and including edge N+1.
- Reset asserted while a message is partially received: the partial message is discarded, and there is no event on the cycle after reset deasserts.
- `reset` takes priority over `rx_valid` in the same cycle.

## Test plan
- Reset, then bytes 90 45 64: at edge N+2, `frequency[0]` = 0x1B800000 and `voice_active` = 0x0001; other voices stay 0.
- Running status 90 3C 40 45 40, then 45 00: voices 0 and 1 become active with note 60 and note 69. Then voice 1 frees: `frequency[1]` = 0 and `voice_active` = 0x0001.
- 17 distinct Note Ons (notes 40-56): voices 0-15 fill. The 17th steals voice 0 (`frequency[0]` = pitch of note 56) and `steal_ptr` becomes 1. A further Note On 57 steals voice 1.
- Channel filtering and realtime bytes:
  - With `MIDI_CHANNEL` = 0 and `OMNI` = 0, bytes 91 45 64 cause no change.
  - Bytes 90 F8 45 FE 64 allocate note 69, because the realtime bytes are ignored.
- Guard cases:
  - Bytes 90 6C 64 (note 108) are ignored.
  - Bytes B0 7B 00 clear all active voices.
  - Sending 90 45 and then asserting `reset` for 1 cycle before 64: no voice becomes active.
